// File: rtl/m10_soc_top.sv
// m10_soc_top: Matrak M10 SoC with one m10_core hart, unified word RAM, 8-bit GPIO register and 8N1 UART transmitter.
// m10_core is a compact single-cycle RV32I hart (no FENCE/SYSTEM) living alongside the top for a self-contained build.
module m10_core (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] inst_addr_o,
    input  logic [31:0] inst_i,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    output logic [3:0]  data_wmask_o,
    output logic        data_we_o,
    output logic        data_re_o,
    input  logic [31:0] data_rdata_i
);
    logic [31:0] pc_q, pc_d, rs1, rs2, imm_i, imm_s, imm_b, imm_j, opb, alu, sra, ld_val, rd_val;
    logic [31:0] rf_q [32];
    logic [15:0] ld_half;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        take, rd_we;

    assign op    = inst_i[6:0];
    assign rd    = inst_i[11:7];
    assign f3    = inst_i[14:12];
    assign rs1   = inst_i[19:15] == 5'd0 ? '0 : rf_q[inst_i[19:15]];
    assign rs2   = inst_i[24:20] == 5'd0 ? '0 : rf_q[inst_i[24:20]];
    assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign opb   = op == 7'h33 ? rs2 : imm_i;
    assign sra   = $signed(rs1) >>> opb[4:0];

    always_comb begin
        case (f3)
            3'd0:    alu = (op == 7'h33 && inst_i[30]) ? rs1 - opb : rs1 + opb;
            3'd1:    alu = rs1 << opb[4:0];
            3'd2:    alu = {31'd0, $signed(rs1) < $signed(opb)};
            3'd3:    alu = {31'd0, rs1 < opb};
            3'd4:    alu = rs1 ^ opb;
            3'd5:    alu = inst_i[30] ? sra : rs1 >> opb[4:0];
            3'd6:    alu = rs1 | opb;
            default: alu = rs1 & opb;
        endcase
    end

    assign take = (f3[2] ? (f3[1] ? rs1 < rs2 : $signed(rs1) < $signed(rs2)) : rs1 == rs2) ^ f3[0];

    // Store data is lane-replicated so the byte mask alone places it in the word.
    assign data_addr_o  = rs1 + (op == 7'h23 ? imm_s : imm_i);
    assign data_wdata_o = f3[1:0] == 2'd0 ? {4{rs2[7:0]}} : f3[1:0] == 2'd1 ? {2{rs2[15:0]}} : rs2;
    assign data_wmask_o = f3[1:0] == 2'd0 ? 4'b0001 << data_addr_o[1:0] :
                          f3[1:0] == 2'd1 ? (data_addr_o[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign data_we_o    = rst_i && op == 7'h23;
    assign data_re_o    = op == 7'h03;
    assign inst_addr_o  = pc_q;

    assign ld_half = 16'(data_rdata_i >> {data_addr_o[1:0], 3'b000});
    assign ld_val  = f3 == 3'd0 ? {{24{ld_half[7]}}, ld_half[7:0]} :
                     f3 == 3'd1 ? {{16{ld_half[15]}}, ld_half} :
                     f3 == 3'd4 ? {24'd0, ld_half[7:0]} :
                     f3 == 3'd5 ? {16'd0, ld_half} : data_rdata_i;

    assign rd_val = op == 7'h37 ? {inst_i[31:12], 12'd0} :
                    op == 7'h17 ? pc_q + {inst_i[31:12], 12'd0} :
                    (op == 7'h6f || op == 7'h67) ? pc_q + 32'd4 :
                    op == 7'h03 ? ld_val : alu;
    assign rd_we  = rst_i && rd != 5'd0 && (op == 7'h37 || op == 7'h17 || op == 7'h6f ||
                    op == 7'h67 || op == 7'h03 || op == 7'h13 || op == 7'h33);
    assign pc_d   = op == 7'h6f ? pc_q + imm_j :
                    op == 7'h67 ? (rs1 + imm_i) & ~32'd1 :
                    (op == 7'h63 && take) ? pc_q + imm_b : pc_q + 32'd4;

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) pc_q <= '0;
        else        pc_q <= pc_d;

    always_ff @(posedge clk_i)
        if (rd_we) rf_q[rd] <= rd_val;
endmodule

module m10_soc_top #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int MEM_WORDS = 4096
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [7:0] gpio_o,
    output logic       uart_tx_o
);
    localparam int CPB = (CLK_FREQ / BAUD) < 1 ? 1 : CLK_FREQ / BAUD;
    localparam int AW  = $clog2(MEM_WORDS);
    localparam int CW  = CPB > 1 ? $clog2(CPB) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_st_e;

    logic [31:0]   ram_q [MEM_WORDS];
    logic [31:0]   inst_addr, inst, data_addr, data_wdata, data_rdata;
    logic [3:0]    data_wmask;
    logic          data_we, data_re, ram_sel, io_sel, tx_wr, baud_end, unused_bits;
    logic [1:0]    io_off;
    logic [AW-1:0] d_idx;
    logic [7:0]    gpio_q, sh_q, sh_d;
    logic [2:0]    bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    uart_st_e      st_q, st_d;

    m10_core u_core (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inst_addr_o (inst_addr),
        .inst_i      (inst),
        .data_addr_o (data_addr),
        .data_wdata_o(data_wdata),
        .data_wmask_o(data_wmask),
        .data_we_o   (data_we),
        .data_re_o   (data_re),
        .data_rdata_i(data_rdata)
    );

    assign ram_sel     = data_addr[31:28] == 4'h0;
    assign io_sel      = data_addr[31:28] == 4'h2;
    assign io_off      = data_addr[3:2];
    assign d_idx       = data_addr[AW+1:2];
    assign unused_bits = ^{data_addr[27:0], inst_addr};

    // Both RAM ports read combinationally, so a fetch of a word stored this cycle sees the old value.
    assign inst       = ram_q[inst_addr[AW+1:2]];
    assign data_rdata = !data_re ? '0 : ram_sel ? ram_q[d_idx] : !io_sel ? '0 :
                        io_off == 2'd0 ? {24'd0, gpio_q} :
                        io_off == 2'd2 ? {31'd0, st_q != IDLE} : '0;

    always_ff @(posedge clk_i)
        if (data_we && ram_sel)
            for (int b = 0; b < 4; b++)
                if (data_wmask[b]) ram_q[d_idx][8*b +: 8] <= data_wdata[8*b +: 8];

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i)                                             gpio_q <= '0;
        else if (data_we && io_sel && io_off == 2'd0 && data_wmask[0]) gpio_q <= data_wdata[7:0];

    assign tx_wr    = data_we && io_sel && io_off == 2'd1;
    assign baud_end = cnt_q == CW'(CPB - 1);

    // Writes arriving outside IDLE are simply dropped; there is no holding register.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        bit_d = bit_q;
        sh_d  = sh_q;
        if (st_q == IDLE) begin
            if (tx_wr) begin
                st_d = START;
                sh_d = data_wdata[7:0];
            end
        end else begin
            cnt_d = baud_end ? '0 : cnt_q + 1'b1;
            if (baud_end) begin
                case (st_q)
                    START: st_d = DATA;
                    DATA: begin
                        sh_d  = sh_q >> 1;
                        bit_d = bit_q + 3'd1;
                        st_d  = bit_q == 3'd7 ? STOP : DATA;
                    end
                    default: st_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            st_q  <= IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            sh_q  <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            sh_q  <= sh_d;
        end

    assign uart_tx_o = st_q == START ? 1'b0 : st_q == DATA ? sh_q[0] : 1'b1;
    assign gpio_o    = gpio_q;
endmodule

// File: tb/tb_m10_soc_top.sv
// tb_m10_soc_top: directed programs for the M10 SoC, checked every cycle against a frame/GPIO-event model.
module tb_m10_soc_top;
    localparam int CPB = 4;

    logic       clk, rst_n;
    logic [7:0] gpio;
    logic       uart_tx;
    int         checks, errors, k;
    logic       run;

    int          fs[$];
    logic [7:0]  fb[$];
    int          ge[$];
    logic [7:0]  gv[$];
    logic [31:0] prog[$];

    m10_soc_top #(.CLK_FREQ(4), .BAUD(1), .MEM_WORDS(256)) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .gpio_o   (gpio),
        .uart_tx_o(uart_tx)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // k counts rising edges since reset release; instruction n retires at edge n+1.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) k <= 0;
        else        k <= k + 1;

    function automatic logic exp_tx(int t);
        logic v;
        v = 1'b1;
        foreach (fs[i])
            if (t >= fs[i] && t < fs[i] + 10 * CPB) begin
                int b;
                b = (t - fs[i]) / CPB;
                v = b == 0 ? 1'b0 : b == 9 ? 1'b1 : fb[i][b-1];
            end
        return v;
    endfunction

    function automatic logic [7:0] exp_gpio(int t);
        logic [7:0] v;
        v = 8'h00;
        foreach (ge[i]) if (t >= ge[i]) v = gv[i];
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk)
        if (run) begin
            check($sformatf("tx@%0d", k), {31'd0, uart_tx}, {31'd0, exp_tx(k)});
            check($sformatf("gpio@%0d", k), {24'd0, gpio}, {24'd0, exp_gpio(k)});
        end

    function automatic logic [31:0] itype(int imm, int rs1, int f3, int rd, int op);
        logic [11:0] im;
        im = 12'(imm);
        return {im, 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] addi(int rd, int rs, int imm); return itype(imm, rs, 0, rd, 'h13); endfunction
    function automatic logic [31:0] andi(int rd, int rs, int imm); return itype(imm, rs, 7, rd, 'h13); endfunction
    function automatic logic [31:0] srli(int rd, int rs, int sh);  return itype(sh, rs, 5, rd, 'h13);  endfunction
    function automatic logic [31:0] lw(int rd, int rs, int imm);   return itype(imm, rs, 2, rd, 'h03); endfunction
    function automatic logic [31:0] lui(int rd, int imm20);        return {20'(imm20), 5'(rd), 7'h37}; endfunction
    function automatic logic [31:0] st(int f3, int rs2, int rs1, int imm);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] bne(int rs1, int rs2, int off);
        logic [12:0] o;
        o = 13'(off);
        return {o[12], o[10:5], 5'(rs2), 5'(rs1), 3'b001, o[4:1], o[11], 7'h63};
    endfunction
    localparam logic [31:0] JSELF = 32'h0000_006f;

    task automatic begin_test();
        @(negedge clk);
        #1 rst_n = 0;
        fs.delete(); fb.delete(); ge.delete(); gv.delete(); prog.delete();
    endtask

    task automatic release_rst();
        foreach (prog[i]) dut.ram_q[i] = prog[i];
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
    endtask

    task automatic run_to(int t);
        for (int i = 0; i < 300 && k < t; i++) @(negedge clk);
        if (k != t) begin
            errors++;
            $display("FAIL run_to: reached %0d wanted %0d", k, t);
        end
    endtask

    initial begin
        checks = 0; errors = 0; run = 1; rst_n = 0;

        // GPIO store: li t0,0xA5; lui t1,0x20000; sw t0,0(t1)
        begin_test();
        prog = '{addi(5, 0, 'hA5), lui(6, 'h20000), st(2, 5, 6, 0), JSELF};
        ge.push_back(3); gv.push_back(8'hA5);
        check("pin_gpio_k2", {24'd0, exp_gpio(2)}, 32'h00);
        release_rst();
        run_to(2);  check("gpio_before_sw", {24'd0, gpio}, 32'h00);
        run_to(3);  check("gpio_after_sw", {24'd0, gpio}, 32'hA5);
        run_to(10);

        // UART 0x55 plus GPIO, then reset mid-frame and re-run from PC 0
        begin_test();
        prog = '{addi(5, 0, 'h55), lui(6, 'h20000), st(0, 5, 6, 4), st(2, 5, 6, 0), JSELF};
        fs.push_back(3); fb.push_back(8'h55);
        ge.push_back(4); gv.push_back(8'h55);
        check("pin_tx_start", {31'd0, exp_tx(3)}, 32'd0);
        check("pin_tx_bit2", {31'd0, exp_tx(15)}, 32'd1);
        check("pin_tx_stop", {31'd0, exp_tx(42)}, 32'd1);
        release_rst();
        run_to(2);  check("tx_idle", {31'd0, uart_tx}, 32'd1);
        run_to(3);  check("tx_start", {31'd0, uart_tx}, 32'd0);
        run_to(4);  check("gpio_55", {24'd0, gpio}, 32'h55);
        run_to(7);  check("tx_bit0", {31'd0, uart_tx}, 32'd1);
        run_to(11); check("tx_bit1", {31'd0, uart_tx}, 32'd0);
        run_to(20);
        #2 rst_n = 0;
        #1;
        check("rst_tx_async", {31'd0, uart_tx}, 32'd1);
        check("rst_gpio_async", {24'd0, gpio}, 32'h00);
        release_rst();
        run_to(3);  check("rerun_tx_start", {31'd0, uart_tx}, 32'd0);
        run_to(50);

        // Second write while busy must be dropped
        begin_test();
        prog = '{addi(5, 0, 'h3C), lui(6, 'h20000), st(0, 5, 6, 4), addi(5, 0, -1), st(0, 5, 6, 4), JSELF};
        fs.push_back(3); fb.push_back(8'h3C);
        release_rst();
        run_to(7);  check("busy_drop_bit0", {31'd0, uart_tx}, 32'd0);
        run_to(60);

        // Poll status then send "Hi" back to back
        begin_test();
        prog = '{lui(6, 'h20000), addi(5, 0, 'h48), lw(7, 6, 8), andi(7, 7, 1), bne(7, 0, -8),
                 st(0, 5, 6, 4), addi(5, 0, 'h69), lw(7, 6, 8), andi(7, 7, 1), bne(7, 0, -8),
                 st(0, 5, 6, 4), JSELF};
        fs.push_back(6);  fb.push_back(8'h48);
        fs.push_back(50); fb.push_back(8'h69);
        release_rst();
        run_to(46); check("hi_gap", {31'd0, uart_tx}, 32'd1);
        run_to(50); check("hi_second_start", {31'd0, uart_tx}, 32'd0);
        run_to(100);

        // Byte store into RAM word 0x100, reload, and an unmapped load
        begin_test();
        dut.ram_q[64] = 32'h1122_3344;
        prog = '{addi(7, 0, 'h100), addi(5, 0, 'h7E), st(0, 5, 7, 1), lw(28, 7, 0), lui(6, 'h20000),
                 srli(29, 28, 8), st(2, 28, 6, 0), st(2, 29, 6, 0), lui(30, 'h30000), lw(31, 30, 0),
                 st(2, 31, 6, 0), JSELF};
        ge.push_back(7);  gv.push_back(8'h44);
        ge.push_back(8);  gv.push_back(8'h7E);
        ge.push_back(11); gv.push_back(8'h00);
        release_rst();
        run_to(8);  check("ram_byte1", {24'd0, gpio}, 32'h7E);
        run_to(14); check("ram_word", dut.ram_q[64], 32'h1122_7E44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
